// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch with branch redirect.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0,
  parameter int STEP     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic [ADDR_W-1:0] o_req_addr,
  input  logic              i_rsp_valid,
  input  logic [DATA_W-1:0] i_rsp_data,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_branch_valid,
  input  logic [ADDR_W-1:0] i_branch_target,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       o_fetch_cnt,
  output logic [15:0]       o_flush_cnt,
`endif
  output logic              o_pc_sel
);

  typedef enum logic [1:0] {S_RST, S_REQ, S_WAIT, S_OUT} state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              kill_r;

  assign o_req_addr = pc_r;

  // Fetch FSM: PC, kill flag and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= S_RST;
      pc_r          <= RESET_PC_V;
      kill_r        <= 1'b0;
      o_req_valid   <= 1'b0;
      o_instr_valid <= 1'b0;
      o_instr       <= '0;
      o_instr_pc    <= '0;
      o_pc_sel      <= 1'b0;
    end else begin
      o_pc_sel <= 1'b0;
      case (state_r)
        S_RST: begin
          state_r     <= S_REQ;
          o_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (i_branch_valid) begin
            pc_r     <= i_branch_target;
            o_pc_sel <= 1'b1;
          end
          if (i_req_ready) begin
            state_r     <= S_WAIT;
            o_req_valid <= 1'b0;
            kill_r      <= i_branch_valid;
          end
        end
        S_WAIT: begin
          if (i_branch_valid) begin
            pc_r     <= i_branch_target;
            o_pc_sel <= 1'b1;
          end
          if (i_rsp_valid) begin
            kill_r <= 1'b0;
            // A same-cycle branch kills the arriving word just like a pending kill.
            if (kill_r || i_branch_valid) begin
              state_r     <= S_REQ;
              o_req_valid <= 1'b1;
            end else begin
              o_instr       <= i_rsp_data;
              o_instr_pc    <= pc_r;
              o_instr_valid <= 1'b1;
              state_r       <= S_OUT;
            end
          end else if (i_branch_valid) begin
            kill_r <= 1'b1;
          end
        end
        S_OUT: begin
          if (i_branch_valid || i_instr_ready) begin
            o_instr_valid <= 1'b0;
            o_req_valid   <= 1'b1;
            state_r       <= S_REQ;
            pc_r          <= i_branch_valid ? i_branch_target : pc_r + STEP_V;
            o_pc_sel      <= i_branch_valid;
          end
        end
        default: begin
          state_r     <= S_RST;
          o_req_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_evt_s;
  logic flush_evt_s;

  // Event decode: a redirect counts as a flush only when it actually drops something.
  always_comb begin
    fetch_evt_s = 1'b0;
    flush_evt_s = 1'b0;
    case (state_r)
      S_REQ: begin
        flush_evt_s = i_branch_valid;
      end
      S_WAIT: begin
        flush_evt_s = i_branch_valid && !kill_r;
      end
      S_OUT: begin
        fetch_evt_s = i_instr_ready;
        flush_evt_s = i_branch_valid && !i_instr_ready;
      end
      default: begin
        fetch_evt_s = 1'b0;
        flush_evt_s = 1'b0;
      end
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fetch_cnt <= 16'h0000;
      o_flush_cnt <= 16'h0000;
    end else begin
      if (fetch_evt_s && (o_fetch_cnt != 16'hFFFF)) begin
        o_fetch_cnt <= o_fetch_cnt + 16'h0001;
      end
      if (flush_evt_s && (o_flush_cnt != 16'hFFFF)) begin
        o_flush_cnt <= o_flush_cnt + 16'h0001;
      end
    end
  end
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (RESET_PC=0 and RESET_PC=8'hFE instances).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_w = 1'b1;
  logic        use_w = 1'b0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_data = 16'h0000;
  logic        instr_ready = 1'b0;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = 8'h00;

  logic        req_valid, instr_valid, pc_sel;
  logic [7:0]  req_addr, instr_pc;
  logic [15:0] instr;
  logic        w_req_valid, w_instr_valid, w_pc_sel;
  logic [7:0]  w_req_addr, w_instr_pc;
  logic [15:0] w_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, flush_cnt, w_fetch_cnt, w_flush_cnt;
`endif

  logic        m_req_valid, m_instr_valid, m_pc_sel;
  logic [7:0]  m_req_addr, m_instr_pc;
  logic [15:0] m_instr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0), .STEP(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_addr(req_addr),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data),
    .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
    .o_instr(instr), .o_instr_pc(instr_pc),
    .i_branch_valid(branch_valid), .i_branch_target(branch_target),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_cnt(fetch_cnt), .o_flush_cnt(flush_cnt),
`endif
    .o_pc_sel(pc_sel)
  );

  pc_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'hFE), .STEP(1)) dut_w (
    .i_clk(clk), .i_rst(rst_w),
    .o_req_valid(w_req_valid), .i_req_ready(req_ready), .o_req_addr(w_req_addr),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data),
    .o_instr_valid(w_instr_valid), .i_instr_ready(instr_ready),
    .o_instr(w_instr), .o_instr_pc(w_instr_pc),
    .i_branch_valid(branch_valid), .i_branch_target(branch_target),
`ifdef FETCH_PERF_CNT_EN
    .o_fetch_cnt(w_fetch_cnt), .o_flush_cnt(w_flush_cnt),
`endif
    .o_pc_sel(w_pc_sel)
  );

  assign m_req_valid   = use_w ? w_req_valid   : req_valid;
  assign m_req_addr    = use_w ? w_req_addr    : req_addr;
  assign m_instr_valid = use_w ? w_instr_valid : instr_valid;
  assign m_instr       = use_w ? w_instr       : instr;
  assign m_instr_pc    = use_w ? w_instr_pc    : instr_pc;
  assign m_pc_sel      = use_w ? w_pc_sel      : pc_sel;

  function automatic logic [15:0] word(input logic [7:0] a);
    return {8'hA5, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full fetch of address a from S_REQ, with 'stall' cycles of decode back-pressure.
  task automatic fetch_one(input logic [7:0] a, input int stall);
    chk("req_valid", 32'(m_req_valid), 32'd1);
    chk("req_addr", 32'(m_req_addr), 32'(a));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("wait_req_low", 32'(m_req_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = word(a);
    tick();
    rsp_valid = 1'b0;
    chk("instr_valid", 32'(m_instr_valid), 32'd1);
    chk("instr", 32'(m_instr), 32'(word(a)));
    chk("instr_pc", 32'(m_instr_pc), 32'(a));
    chk("pc_sel_seq", 32'(m_pc_sel), 32'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 32'(m_instr_valid), 32'd1);
      chk("stall_instr", 32'(m_instr), 32'(word(a)));
      chk("stall_pc", 32'(m_instr_pc), 32'(a));
      chk("stall_no_req", 32'(m_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("accept_clear", 32'(m_instr_valid), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", 32'(req_addr), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_w_addr", 32'(w_req_addr), 32'h0FE);
    chk("rst_w_valid", 32'(w_req_valid), 32'd0);

    rst = 1'b0;
    tick();
    fetch_one(8'h00, 0);
    fetch_one(8'h01, 0);
    fetch_one(8'h02, 0);
    fetch_one(8'h03, 0);
    fetch_one(8'h04, 0);

    // Branch in S_WAIT while fetching 05.
    chk("b5_addr", 32'(req_addr), 32'h05);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_valid = 1'b0;
    chk("b5_pc_sel", 32'(pc_sel), 32'd1);
    chk("b5_no_instr", 32'(instr_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = word(8'h05);
    tick();
    rsp_valid = 1'b0;
    chk("b5_dropped", 32'(instr_valid), 32'd0);
    chk("b5_req_valid", 32'(req_valid), 32'd1);
    chk("b5_req_addr", 32'(req_addr), 32'h40);
    chk("b5_pc_sel_once", 32'(pc_sel), 32'd0);
    fetch_one(8'h40, 0);

    // Decode back-pressure.
    fetch_one(8'h41, 5);
    fetch_one(8'h42, 0);

    // Branch in S_REQ without handshake.
    branch_valid  = 1'b1;
    branch_target = 8'h20;
    tick();
    branch_valid = 1'b0;
    chk("breq_valid", 32'(req_valid), 32'd1);
    chk("breq_addr", 32'(req_addr), 32'h20);
    chk("breq_pc_sel", 32'(pc_sel), 32'd1);
    fetch_one(8'h20, 0);

    // Branch and accept together in S_OUT.
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = word(8'h21);
    tick();
    rsp_valid = 1'b0;
    chk("bout_valid", 32'(instr_valid), 32'd1);
    instr_ready   = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 8'h30;
    tick();
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    chk("bout_clear", 32'(instr_valid), 32'd0);
    chk("bout_addr", 32'(req_addr), 32'h30);
    chk("bout_pc_sel", 32'(pc_sel), 32'd1);

    // Branch on the handshake cycle: the response must be killed.
    req_ready     = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 8'h50;
    tick();
    req_ready    = 1'b0;
    branch_valid = 1'b0;
    chk("bhs_req_low", 32'(req_valid), 32'd0);
    chk("bhs_pc_sel", 32'(pc_sel), 32'd1);
    rsp_valid = 1'b1;
    rsp_data  = word(8'h30);
    tick();
    rsp_valid = 1'b0;
    chk("bhs_dropped", 32'(instr_valid), 32'd0);
    chk("bhs_req_addr", 32'(req_addr), 32'h50);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", 32'(fetch_cnt), 32'd10);
    chk("flush_cnt", 32'(flush_cnt), 32'd3);
`endif

    // Reset in S_WAIT followed by a stale response.
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_req_valid", 32'(req_valid), 32'd0);
    chk("mrst_addr", 32'(req_addr), 32'd0);
    chk("mrst_instr_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("mrst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    rst       = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = word(8'h50);
    tick();
    rsp_valid = 1'b0;
    chk("stale_ignored", 32'(instr_valid), 32'd0);
    chk("stale_req", 32'(req_valid), 32'd1);
    tick();
    chk("stale_still", 32'(instr_valid), 32'd0);
    fetch_one(8'h00, 0);

    // Wrap-around from RESET_PC=FE.
    rst   = 1'b1;
    use_w = 1'b1;
    rst_w = 1'b0;
    tick();
    fetch_one(8'hFE, 0);
    fetch_one(8'hFF, 0);
    fetch_one(8'h00, 0);
    fetch_one(8'h01, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
